// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns the Bee-Scape obstacle slots. It spawns obstacles
// at the right edge with a pseudo-random gap height and scrolls them left
// every frame. It retires slots that leave the screen and counts obstacles
// the bee has passed.
module obstacle_scheduler #(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SPAWN_X      = 640,
    parameter int          Y_MIN        = 100,
    parameter int          OBS_W        = 50,
    parameter int          OBS_H        = 40,
    parameter int          SPAWN_PERIOD = 90,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      game_over,
    input  logic [3:0]                speed,
    input  logic [9:0]                bee_x,
    output logic [NUM_SLOTS*10-1:0]   ObsX,
    output logic [NUM_SLOTS*10-1:0]   ObsY,
    output logic [NUM_SLOTS-1:0]      ObsActive,
    output logic [9:0]                ObsWidth,
    output logic [9:0]                ObsHeight,
    output logic [7:0]                score,
    output logic [1:0]                state
);

    localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
    localparam int HIT_W = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // One Galois step of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ 16'hB400;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Registered state
    state_t                state_r;
    logic [9:0]            x_r      [NUM_SLOTS];
    logic [9:0]            y_r      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  active_r;
    logic [NUM_SLOTS-1:0]  scored_r;
    logic [7:0]            score_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [15:0]           lfsr_r;
    logic [9:0]            width_r;
    logic [9:0]            height_r;

    // Next-frame values for a normal RUN edge
    logic [9:0]            x_nx_s   [NUM_SLOTS];
    logic [9:0]            y_nx_s   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  active_nx_s;
    logic [NUM_SLOTS-1:0]  scored_nx_s;
    logic [HIT_W-1:0]      hit_cnt_s;
    logic [8:0]            score_sum_s;
    logic [7:0]            score_nx_s;
    logic                  spawn_due_s;
    logic                  spawn_taken_s;
    logic [CNT_W-1:0]      cnt_nx_s;
    logic [15:0]           lfsr_nx_s;
    logic [9:0]            spawn_y_s;

    // Compute one frame of move / retire / score / spawn from the current slots.
    always_comb begin
        lfsr_nx_s     = lfsr_next(lfsr_r);
        spawn_due_s   = (cnt_r == CNT_W'(SPAWN_PERIOD - 1));
        cnt_nx_s      = spawn_due_s ? '0 : (cnt_r + CNT_W'(1));
        spawn_y_s     = 10'(Y_MIN) + {2'b00, lfsr_r[7:0]};
        spawn_taken_s = 1'b0;
        hit_cnt_s     = '0;
        active_nx_s   = active_r;
        scored_nx_s   = scored_r;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_nx_s[i] = x_r[i];
            y_nx_s[i] = y_r[i];
            if (active_r[i]) begin
                if (x_r[i] >= {6'd0, speed}) begin
                    x_nx_s[i] = x_r[i] - {6'd0, speed};
                    // Right edge strictly left of the bee counts as passed, once.
                    if (!scored_r[i] && (({1'b0, x_nx_s[i]} + 11'(OBS_W)) < {1'b0, bee_x})) begin
                        scored_nx_s[i] = 1'b1;
                        hit_cnt_s      = hit_cnt_s + HIT_W'(1);
                    end else begin
                        scored_nx_s[i] = scored_r[i];
                    end
                end else begin
                    // Leaving the screen: free the slot for a later spawn.
                    x_nx_s[i]      = 10'd0;
                    active_nx_s[i] = 1'b0;
                    scored_nx_s[i] = 1'b0;
                end
            end else if (spawn_due_s && !spawn_taken_s) begin
                // Only slots already free at the start of the frame are eligible.
                spawn_taken_s  = 1'b1;
                x_nx_s[i]      = 10'(SPAWN_X);
                y_nx_s[i]      = spawn_y_s;
                active_nx_s[i] = 1'b1;
                scored_nx_s[i] = 1'b0;
            end else begin
                x_nx_s[i] = x_r[i];
            end
        end
        score_sum_s = {1'b0, score_r} + 9'(hit_cnt_s);
        if (score_sum_s > 9'd255) begin
            score_nx_s = 8'd255;
        end else begin
            score_nx_s = score_sum_s[7:0];
        end
    end

    // Game FSM and all slot/score/LFSR registers; every output comes from here.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_IDLE;
            active_r <= '0;
            scored_r <= '0;
            score_r  <= 8'd0;
            cnt_r    <= '0;
            lfsr_r   <= LFSR_SEED;
            width_r  <= 10'(OBS_W);
            height_r <= 10'(OBS_H);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_r[i] <= 10'd0;
                y_r[i] <= 10'd0;
            end
        end else begin
            width_r  <= 10'(OBS_W);
            height_r <= 10'(OBS_H);
            case (state_r)
                ST_IDLE, ST_FROZEN: begin
                    if (start) begin
                        // New game: empty field, fresh score and a reseeded sequence.
                        state_r  <= ST_RUN;
                        active_r <= '0;
                        scored_r <= '0;
                        score_r  <= 8'd0;
                        cnt_r    <= '0;
                        lfsr_r   <= LFSR_SEED;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            x_r[i] <= 10'd0;
                            y_r[i] <= 10'd0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (game_over) begin
                        // Freeze edge commits nothing else.
                        state_r <= ST_FROZEN;
                    end else begin
                        state_r  <= ST_RUN;
                        active_r <= active_nx_s;
                        scored_r <= scored_nx_s;
                        score_r  <= score_nx_s;
                        cnt_r    <= cnt_nx_s;
                        lfsr_r   <= lfsr_nx_s;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            x_r[i] <= x_nx_s[i];
                            y_r[i] <= y_nx_s[i];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pack slot registers onto the flat position buses.
    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_pack
            assign ObsX[10*g +: 10] = x_r[g];
            assign ObsY[10*g +: 10] = y_r[g];
        end
    endgenerate

    assign ObsActive = active_r;
    assign ObsWidth  = width_r;
    assign ObsHeight = height_r;
    assign score     = score_r;
    assign state     = state_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed testbench for obstacle_scheduler with default parameters.
module tb_obstacle_scheduler;

    logic        frame_clk;
    logic        Reset;
    logic        start;
    logic        game_over;
    logic [3:0]  speed;
    logic [9:0]  bee_x;
    logic [39:0] ObsX;
    logic [39:0] ObsY;
    logic [3:0]  ObsActive;
    logic [9:0]  ObsWidth;
    logic [9:0]  ObsHeight;
    logic [7:0]  score;
    logic [1:0]  state;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] lfsr_tmp;
    logic [9:0]  y_first;
    logic [9:0]  y_second;

    obstacle_scheduler dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .start     (start),
        .game_over (game_over),
        .speed     (speed),
        .bee_x     (bee_x),
        .ObsX      (ObsX),
        .ObsY      (ObsY),
        .ObsActive (ObsActive),
        .ObsWidth  (ObsWidth),
        .ObsHeight (ObsHeight),
        .score     (score),
        .state     (state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Reference LFSR: advance n times, feedback taps 16,14,13,11.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < n; k++) begin
            r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [9:0] slot_x(input int i);
        return ObsX[10*i +: 10];
    endfunction

    function automatic logic [9:0] slot_y(input int i);
        return ObsY[10*i +: 10];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n frames and settle 1 time unit past the last edge.
    task automatic clk_edges(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    initial begin
        Reset     = 1'b0;
        start     = 1'b0;
        game_over = 1'b0;
        speed     = 4'd2;
        bee_x     = 10'd0;

        // First spawn uses the value before the 90th step, i.e. after 89 steps.
        lfsr_tmp = lfsr_adv(16'hACE1, 89);
        y_first  = 10'd100 + {2'b00, lfsr_tmp[7:0]};
        lfsr_tmp = lfsr_adv(16'hACE1, 179);
        y_second = 10'd100 + {2'b00, lfsr_tmp[7:0]};

        // Reset and idle.
        clk_edges(2);
        Reset = 1'b1;
        clk_edges(10);
        check_val("rst_state",  32'(state), 32'd0);
        check_val("rst_active", 32'(ObsActive), 32'd0);
        check_val("rst_score",  32'(score), 32'd0);
        check_val("rst_x",      32'(ObsX), 32'd0);
        check_val("width",      32'(ObsWidth), 32'd50);
        check_val("height",     32'(ObsHeight), 32'd40);

        // Start with speed 2.
        start = 1'b1;
        clk_edges(1);
        start = 1'b0;
        check_val("run_state", 32'(state), 32'd1);
        clk_edges(89);
        check_val("e89_active", 32'(ObsActive), 32'd0);
        clk_edges(1);
        check_val("e90_active", 32'(ObsActive), 32'd1);
        check_val("e90_x0",     32'(slot_x(0)), 32'd640);
        check_val("e90_y0",     32'(slot_y(0)), 32'(y_first));
        clk_edges(1);
        check_val("e91_x0",     32'(slot_x(0)), 32'd638);

        // Freeze: freezing edge performs no move; game_over ignored while frozen.
        game_over = 1'b1;
        clk_edges(1);
        check_val("frz_state", 32'(state), 32'd2);
        check_val("frz_x0",    32'(slot_x(0)), 32'd638);
        clk_edges(5);
        game_over = 1'b0;
        speed     = 4'd7;
        clk_edges(15);
        check_val("frz20_state",  32'(state), 32'd2);
        check_val("frz20_x0",     32'(slot_x(0)), 32'd638);
        check_val("frz20_y0",     32'(slot_y(0)), 32'(y_first));
        check_val("frz20_active", 32'(ObsActive), 32'd1);
        check_val("frz20_score",  32'(score), 32'd0);

        // Restart with speed 15, bee at 200.
        speed = 4'd15;
        bee_x = 10'd200;
        start = 1'b1;
        clk_edges(1);
        start = 1'b0;
        check_val("rs_state",  32'(state), 32'd1);
        check_val("rs_active", 32'(ObsActive), 32'd0);
        check_val("rs_x0",     32'(slot_x(0)), 32'd0);
        check_val("rs_score",  32'(score), 32'd0);
        clk_edges(90);
        check_val("rs90_active", 32'(ObsActive), 32'd1);
        check_val("rs90_y0",     32'(slot_y(0)), 32'(y_first));
        clk_edges(32);
        check_val("e122_x0",    32'(slot_x(0)), 32'd160);
        check_val("e122_score", 32'(score), 32'd0);
        clk_edges(1);
        check_val("e123_x0",    32'(slot_x(0)), 32'd145);
        check_val("e123_score", 32'(score), 32'd1);
        clk_edges(9);
        check_val("e132_x0",     32'(slot_x(0)), 32'd10);
        check_val("e132_active", 32'(ObsActive), 32'd1);
        check_val("e132_score",  32'(score), 32'd1);
        clk_edges(1);
        check_val("e133_active", 32'(ObsActive), 32'd0);
        check_val("e133_x0",     32'(slot_x(0)), 32'd0);
        check_val("e133_score",  32'(score), 32'd1);
        clk_edges(47);
        check_val("e180_active", 32'(ObsActive), 32'd1);
        check_val("e180_x0",     32'(slot_x(0)), 32'd640);
        check_val("e180_y0",     32'(slot_y(0)), 32'(y_second));
        clk_edges(33);
        check_val("e213_x0",    32'(slot_x(0)), 32'd145);
        check_val("e213_score", 32'(score), 32'd2);

        // Asynchronous reset between edges.
        #3;
        Reset = 1'b0;
        #1;
        check_val("arst_state",  32'(state), 32'd0);
        check_val("arst_active", 32'(ObsActive), 32'd0);
        check_val("arst_score",  32'(score), 32'd0);
        check_val("arst_x",      32'(ObsX), 32'd0);
        check_val("arst_y",      32'(ObsY), 32'd0);
        clk_edges(2);
        Reset = 1'b1;
        clk_edges(2);
        check_val("post_rst_state", 32'(state), 32'd0);

        // start and game_over together in IDLE: RUN first, FROZEN next edge.
        start     = 1'b1;
        game_over = 1'b1;
        clk_edges(1);
        start = 1'b0;
        check_val("sg_run", 32'(state), 32'd1);
        clk_edges(1);
        check_val("sg_frozen", 32'(state), 32'd2);

        // Speed 0: slots fill in order, fifth spawn is dropped.
        game_over = 1'b0;
        speed     = 4'd0;
        start     = 1'b1;
        clk_edges(1);
        start = 1'b0;
        clk_edges(90);
        check_val("fill1", 32'(ObsActive), 32'h1);
        clk_edges(90);
        check_val("fill2", 32'(ObsActive), 32'h3);
        clk_edges(90);
        check_val("fill3", 32'(ObsActive), 32'h7);
        clk_edges(90);
        check_val("fill4",    32'(ObsActive), 32'hF);
        check_val("fill4_x3", 32'(slot_x(3)), 32'd640);
        clk_edges(90);
        check_val("drop_active", 32'(ObsActive), 32'hF);
        check_val("drop_x0",     32'(slot_x(0)), 32'd640);
        check_val("drop_x2",     32'(slot_x(2)), 32'd640);
        check_val("drop_y0",     32'(slot_y(0)), 32'(y_first));
        check_val("drop_score",  32'(score), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
